pulse_stretcher: RTL and testbench

- Output-side counterpart to the input debouncer. The debouncer rejects input pulses that are too short; this block guarantees that output pulses are long enough.
- Takes a request signal A, which may be a single-cycle strobe or a level, and drives B with a guaranteed minimum high time and minimum low time.
- Used for LED indicators, OLED panel control strobes (VDD/VBAT enables, RES), and any other output that must not glitch faster than a fixed number of clocks.

---
 rtl/pulse_pkg.sv | 25 ++
 rtl/pulse_stretcher.sv | 85 ++++++++
 tb/tb_pulse_stretcher.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the output pulse stretcher: state encoding, bit
// positions within the state word, and a counter sizing helper.
package pulse_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned B_BIT    = 1;
  localparam int unsigned HOLD_BIT = 0;

  // bit1 drives B, bit0 enables the hold counter
  typedef enum logic [STATE_W-1:0] {
    OFF_IDLE = 2'b00,
    OFF_HOLD = 2'b01,
    ON_IDLE  = 2'b10,
    ON_HOLD  = 2'b11
  } pulse_state_e;

  // Smallest width w (at least 1) with 2**w >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((w < 31) && ((32'd1 << w) < value)) w = w + 1;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Shapes a strobe or level request A into output B with guaranteed minimum
// high and low times; requests during the low hold are deferred and merged.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int unsigned HIGH_MIN    = 4,
  parameter int unsigned LOW_MIN     = 4,
  parameter int unsigned COUNT_WIDTH = 3,
  parameter bit          RETRIGGER   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  output logic B,
  output logic busy
);

  localparam logic [COUNT_WIDTH-1:0] HIGH_LAST = COUNT_WIDTH'(HIGH_MIN - 1);
  localparam logic [COUNT_WIDTH-1:0] LOW_LAST  = COUNT_WIDTH'(LOW_MIN - 1);

  pulse_state_e           state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   pending_q, pending_d;
  logic                   a_q;
  logic                   rise;
  logic                   restart;

  assign rise = A & ~a_q;

  // Next state, deferred-request flag and hold counter
  always_comb begin
    state_d   = state_q;
    pending_d = 1'b0;
    restart   = 1'b0;
    case (state_q)
      OFF_IDLE: begin
        if (A) state_d = ON_HOLD;
      end
      ON_HOLD: begin
        // retrigger beats terminal count in the same cycle
        if (RETRIGGER && rise) begin
          restart = 1'b1;
        end else if (count_q == HIGH_LAST) begin
          state_d = A ? ON_IDLE : OFF_HOLD;
        end
      end
      ON_IDLE: begin
        if (!A) state_d = OFF_HOLD;
      end
      OFF_HOLD: begin
        if (count_q == LOW_LAST) begin
          state_d = (pending_q | A) ? ON_HOLD : OFF_IDLE;
        end else begin
          pending_d = pending_q | A;
        end
      end
      default: state_d = OFF_IDLE;
    endcase

    if (restart || (state_d != state_q) || !state_q[HOLD_BIT]) begin
      count_d = '0;
    end else begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // State, counter and request history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OFF_IDLE;
      count_q   <= '0;
      pending_q <= 1'b0;
      a_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      a_q       <= A;
    end
  end

  assign B    = state_q[B_BIT];
  assign busy = state_q[HOLD_BIT];

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: three configurations share one request
// stream and are compared each cycle against a countdown reference model.
module tb_pulse_stretcher;

  localparam int NDUT = 3;

  logic clk;
  logic rst;
  logic a;
  logic b0, b1, b2;
  logic busy0, busy1, busy2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [NDUT-1:0] b;
    logic [NDUT-1:0] busy;
  } exp_t;

  exp_t sb[$];

  // Reference model state, one slot per configuration
  int   m_high [NDUT] = '{4, 4, 1};
  int   m_low  [NDUT] = '{3, 3, 1};
  logic m_retr [NDUT] = '{1'b1, 1'b0, 1'b1};
  logic m_on   [NDUT];
  logic m_hold [NDUT];
  int   m_left [NDUT];
  logic m_defer[NDUT];
  logic m_aq   [NDUT];

  int hi_cnt  [NDUT];
  int busy_cnt[NDUT];

  pulse_stretcher #(.HIGH_MIN(4), .LOW_MIN(3), .COUNT_WIDTH(3), .RETRIGGER(1'b1)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b0), .busy(busy0)
  );

  pulse_stretcher #(.HIGH_MIN(4), .LOW_MIN(3), .COUNT_WIDTH(3), .RETRIGGER(1'b0)) dut_noretrig (
    .clk(clk), .rst(rst), .A(a), .B(b1), .busy(busy1)
  );

  pulse_stretcher #(.HIGH_MIN(1), .LOW_MIN(1), .COUNT_WIDTH(1), .RETRIGGER(1'b1)) dut_min (
    .clk(clk), .rst(rst), .A(a), .B(b2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Remaining-cycles formulation of the shaping rules
  task automatic model_step(input int i, input logic a_v, input logic rst_v);
    if (rst_v) begin
      m_on[i] = 1'b0; m_hold[i] = 1'b0; m_left[i] = 0; m_defer[i] = 1'b0;
    end else if (!m_on[i] && !m_hold[i]) begin
      if (a_v) begin
        m_on[i] = 1'b1; m_hold[i] = 1'b1; m_left[i] = m_high[i];
      end
    end else if (m_on[i] && m_hold[i]) begin
      if (m_retr[i] && a_v && !m_aq[i]) begin
        m_left[i] = m_high[i];
      end else if (m_left[i] == 1) begin
        if (a_v) begin
          m_hold[i] = 1'b0;
        end else begin
          m_on[i] = 1'b0; m_left[i] = m_low[i]; m_defer[i] = 1'b0;
        end
      end else begin
        m_left[i] = m_left[i] - 1;
      end
    end else if (m_on[i]) begin
      if (!a_v) begin
        m_on[i] = 1'b0; m_hold[i] = 1'b1; m_left[i] = m_low[i]; m_defer[i] = 1'b0;
      end
    end else begin
      if (m_left[i] == 1) begin
        if (m_defer[i] || a_v) begin
          m_on[i] = 1'b1; m_left[i] = m_high[i];
        end else begin
          m_hold[i] = 1'b0;
        end
        m_defer[i] = 1'b0;
      end else begin
        m_left[i]  = m_left[i] - 1;
        m_defer[i] = m_defer[i] | a_v;
      end
    end
    m_aq[i] = rst_v ? 1'b0 : a_v;
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic cycle(input logic a_v, input logic rst_v);
    exp_t e;
    logic [NDUT-1:0] act_b, act_busy;
    a   = a_v;
    rst = rst_v;
    for (int i = 0; i < NDUT; i++) begin
      model_step(i, a_v, rst_v);
      e.b[i]    = m_on[i];
      e.busy[i] = m_hold[i];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e        = sb.pop_front();
    act_b    = {b2, b1, b0};
    act_busy = {busy2, busy1, busy0};
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("B[%0d] cyc=%0d", i, cyc), 32'(act_b[i]), 32'(e.b[i]));
      check($sformatf("busy[%0d] cyc=%0d", i, cyc), 32'(act_busy[i]), 32'(e.busy[i]));
      if (act_b[i] === 1'b1) hi_cnt[i]++;
      if (act_busy[i] === 1'b1) busy_cnt[i]++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NDUT; i++) begin
      hi_cnt[i]   = 0;
      busy_cnt[i] = 0;
    end
  endtask

  initial begin
    a   = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      m_on[i] = 1'b0; m_hold[i] = 1'b0; m_left[i] = 0; m_defer[i] = 1'b0; m_aq[i] = 1'b0;
    end
    repeat (3) cycle(1'b0, 1'b1);
    idle(2);

    // Reset aborts a high hold; a later strobe gives a fresh full pulse
    clear_counts();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("reset_b", 32'(b0), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    idle(2);
    cycle(1'b1, 1'b0);
    idle(10);
    check("reset_width", 32'(hi_cnt[0]), 32'd6);

    // Single strobe
    clear_counts();
    cycle(1'b1, 1'b0);
    idle(10);
    check("strobe_width", 32'(hi_cnt[0]), 32'd4);
    check("strobe_busy", 32'(busy_cnt[0]), 32'd7);
    check("strobe_width_min", 32'(hi_cnt[2]), 32'd1);

    // Level request of ten cycles
    clear_counts();
    repeat (10) cycle(1'b1, 1'b0);
    idle(10);
    check("level_width", 32'(hi_cnt[0]), 32'd10);
    check("level_busy", 32'(busy_cnt[0]), 32'd7);

    // Second strobe lands inside the low hold
    clear_counts();
    cycle(1'b1, 1'b0);
    idle(5);
    cycle(1'b1, 1'b0);
    idle(12);
    check("deferred_width", 32'(hi_cnt[0]), 32'd8);
    check("deferred_busy", 32'(busy_cnt[0]), 32'd14);

    // Retrigger during the high hold
    clear_counts();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    idle(12);
    check("retrig_width", 32'(hi_cnt[0]), 32'd6);
    check("noretrig_width", 32'(hi_cnt[1]), 32'd4);

    // Level with a one-cycle drop: low hold enforced, no idle gap after it
    clear_counts();
    repeat (10) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (15) cycle(1'b1, 1'b0);
    idle(12);
    check("b2b_width", 32'(hi_cnt[0]), 32'd23);

    // Random requests with occasional reset
    repeat (400) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0));
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
